// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply-divide control block: op codes,
// controller states and the default divider timeout.
package md_pkg;

  typedef enum logic [2:0] {
    OpNop   = 3'd0,
    OpDiv   = 3'd1,
    OpMult  = 3'd2,
    OpMultu = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StDivArm,
    StDivRun,
    StDivDone
  } md_state_e;

  localparam int unsigned DivTimeoutDefault = 40;
  localparam int unsigned CntWidth          = 6;

  function automatic logic is_mult_op(logic [2:0] op);
    return (op == OpMult) || (op == OpMultu);
  endfunction

endpackage

// File: rtl/mult32.sv
// Combinational 32x32 multiplier producing a 64-bit signed or unsigned product.
module mult32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic [63:0] p
);

  logic [65:0] a_ext;
  logic [65:0] b_ext;
  logic [65:0] prod;

  // Extending to 66 bits makes one unsigned multiply serve both signednesses;
  // the low 64 bits of the truncated product are exact in either case.
  always_comb begin
    a_ext = {{34{is_signed & a[31]}}, a};
    b_ext = {{34{is_signed & b[31]}}, b};
    prod  = a_ext * b_ext;
    p     = prod[63:0];
  end

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO register controller: single-cycle MULT/MULTU/MTHI/MTLO and a stalling
// handshake with an external iterative signed divider, with timeout abort.
module hilo_ctrl
  import md_pkg::*;
#(
  parameter int unsigned DIV_TIMEOUT = DivTimeoutDefault
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_busy,
  output logic        div_zero,
  output logic        div_err
);

  md_state_e           state_q, state_d;
  logic [31:0]         hi_q, hi_d;
  logic [31:0]         lo_q, lo_d;
  logic [31:0]         dvd_q, dvd_d;
  logic [31:0]         dvs_q, dvs_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                zero_q, zero_d;
  logic                err_q, err_d;

  logic [63:0] prod;
  logic        timeout;

  mult32 u_mult32 (
    .a         (rs_val),
    .b         (rt_val),
    .is_signed (op == OpMult),
    .p         (prod)
  );

  assign timeout = (cnt_q == CntWidth'(DIV_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    zero_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          if (is_mult_op(op)) begin
            {hi_d, lo_d} = prod;
          end else begin
            case (op)
              OpMthi: hi_d = rs_val;
              OpMtlo: lo_d = rs_val;
              OpDiv: begin
                if (rt_val == '0) begin
                  zero_d = 1'b1;
                end else begin
                  dvd_d   = rs_val;
                  dvs_d   = rt_val;
                  cnt_d   = '0;
                  state_d = StDivArm;
                end
              end
              default: ;
            endcase
          end
        end
      end

      // Divider progress wins over a timeout landing on the same cycle.
      StDivArm: begin
        cnt_d = cnt_q + 1'b1;
        if (div_busy) begin
          state_d = StDivRun;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end

      StDivRun: begin
        cnt_d = cnt_q + 1'b1;
        if (!div_busy) begin
          state_d = StDivDone;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end

      StDivDone: begin
        lo_d    = div_q;
        hi_d    = div_r;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign hi           = hi_q;
  assign lo           = lo_q;
  assign stall        = (state_q != StIdle);
  assign div_start    = (state_q == StDivArm);
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign div_zero     = zero_q;
  assign div_err      = err_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed and random checks of hilo_ctrl against an arithmetic HI/LO model,
// with a 32-iteration divider model driving the div_* handshake.
module tb_hilo_ctrl;
  import md_pkg::*;

  localparam int unsigned Timeout = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic [31:0] hi, lo;
  logic        stall, div_start, div_zero, div_err;
  logic [31:0] div_dividend, div_divisor;
  logic [31:0] div_q, div_r;
  logic        div_busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] hi_m, lo_m;

  logic        div_rst_n;
  logic        div_hang;
  int unsigned dcnt;
  logic [31:0] dq_n, dr_n;

  always #5 clock = ~clock;

  hilo_ctrl #(.DIV_TIMEOUT(Timeout)) dut (
    .clock        (clock),
    .reset        (reset),
    .op_valid     (op_valid),
    .op           (op),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .hi           (hi),
    .lo           (lo),
    .stall        (stall),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_q        (div_q),
    .div_r        (div_r),
    .div_busy     (div_busy),
    .div_zero     (div_zero),
    .div_err      (div_err)
  );

  // Divider: latches operands when started, busy for 32 cycles, then presents q/r.
  always @(posedge clock or negedge div_rst_n) begin
    if (!div_rst_n) begin
      div_busy <= 1'b0;
      dcnt     <= 0;
      div_q    <= '0;
      div_r    <= '0;
      dq_n     <= '0;
      dr_n     <= '0;
    end else if (div_busy) begin
      if (dcnt == 31) begin
        div_busy <= 1'b0;
        div_q    <= dq_n;
        div_r    <= dr_n;
      end
      dcnt <= dcnt + 1;
    end else if (div_start && !div_hang) begin
      div_busy <= 1'b1;
      dcnt     <= 0;
      dq_n     <= 32'(int'(div_dividend) / int'(div_divisor));
      dr_n     <= 32'(int'(div_dividend) % int'(div_divisor));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    case (o)
      OpMult: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        {hi_m, lo_m} = sp;
      end
      OpMultu: begin
        up = {32'b0, a} * {32'b0, b};
        {hi_m, lo_m} = up;
      end
      OpMthi: hi_m = a;
      OpMtlo: lo_m = a;
      OpDiv: begin
        if (b != 0) begin
          lo_m = 32'(int'(a) / int'(b));
          hi_m = 32'(int'(a) % int'(b));
        end
      end
      default: ;
    endcase
  endtask

  // Presents one op for one edge; the model follows unless the divider is hung.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic v = 1'b1);
    op_valid = v;
    op       = o;
    rs_val   = a;
    rt_val   = b;
    tick();
    op_valid = 1'b0;
    if (v && !div_hang) model_op(o, a, b);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (stall && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("idle_wait", {63'b0, stall}, 64'd0);
  endtask

  initial begin
    int    lat, starts, cyc;
    logic  stable, seen;
    md_op_e ops [6] = '{OpNop, OpDiv, OpMult, OpMultu, OpMthi, OpMtlo};
    logic [2:0]  o;
    logic [31:0] a, b;
    logic        v;

    reset     = 1'b1;
    div_rst_n = 1'b0;
    div_hang  = 1'b0;
    op_valid  = 1'b0;
    op        = OpNop;
    rs_val    = '0;
    rt_val    = '0;
    hi_m      = '0;
    lo_m      = '0;
    #1 reset = 1'b0;
    #2;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_ctl", {60'b0, stall, div_start, div_zero, div_err}, 64'd0);
    chk("rst_opnd", {div_dividend, div_divisor}, 64'd0);
    tick();
    tick();
    reset     = 1'b1;
    div_rst_n = 1'b1;

    issue(OpMult, 32'hFFFF_FFFF, 32'h2);
    chk("mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mult_stall", {63'b0, stall}, 64'd0);
    issue(OpMultu, 32'hFFFF_FFFF, 32'h2);
    chk("multu", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    issue(OpMthi, 32'h11, 32'h0);
    chk("mthi", {hi, lo}, 64'h0000_0011_FFFF_FFFE);
    issue(OpMtlo, 32'h22, 32'h0);
    chk("mtlo", {hi, lo}, 64'h0000_0011_0000_0022);

    issue(OpDiv, 32'd5, 32'd0);
    chk("dz_pulse", {62'b0, div_zero, stall}, 64'd2);
    chk("dz_start", {63'b0, div_start}, 64'd0);
    chk("dz_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
    tick();
    chk("dz_end", {61'b0, div_zero, stall, div_start}, 64'd0);

    issue(OpDiv, 32'd7, 32'd2);
    chk("div_arm", {62'b0, stall, div_start}, 64'd3);
    lat    = 0;
    starts = 1;
    stable = 1'b1;
    while (stall && lat < 200) begin
      if (lat == 5) begin
        op_valid = 1'b1;
        op       = OpMthi;
        rs_val   = 32'hA;
      end else begin
        op_valid = 1'b0;
      end
      tick();
      lat++;
      if (div_start) starts++;
      if (stall && (div_dividend !== 32'd7 || div_divisor !== 32'd2)) stable = 1'b0;
    end
    op_valid = 1'b0;
    chk("div_lat_ok", {63'b0, (lat >= 32 && lat <= 36)}, 64'd1);
    chk("div_start_len", 64'(starts), 64'd2);
    chk("div_opnd_stable", {63'b0, stable}, 64'd1);
    chk("div_7_2", {hi, lo}, 64'h0000_0001_0000_0003);
    hi_m = 32'd1;
    lo_m = 32'd3;

    issue(OpDiv, 32'hFFFF_FFF9, 32'd2);
    wait_idle(cyc);
    chk("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    issue(OpMthi, 32'h55, 32'h0);
    issue(OpMtlo, 32'h66, 32'h0);
    div_hang = 1'b1;
    issue(OpDiv, 32'd9, 32'd4);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      tick();
      cyc++;
      seen = div_err;
    end
    chk("to_seen", {63'b0, seen}, 64'd1);
    chk("to_lat", 64'(cyc), 64'(Timeout));
    chk("to_stall", {63'b0, stall}, 64'd0);
    chk("to_hilo", {hi, lo}, 64'h0000_0055_0000_0066);
    tick();
    chk("to_end", {63'b0, div_err}, 64'd0);
    div_hang = 1'b0;

    issue(OpDiv, 32'd100, 32'd3);
    repeat (10) tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_hilo", {hi, lo}, 64'd0);
    chk("rst_mid_ctl", {62'b0, stall, div_start}, 64'd0);
    hi_m = '0;
    lo_m = '0;
    tick();
    tick();
    reset = 1'b1;
    issue(OpMthi, 32'h77, 32'h0);
    chk("rst_first_op", {hi, lo}, 64'h0000_0077_0000_0000);
    repeat (40) tick();
    chk("rst_no_write", {hi, lo}, 64'h0000_0077_0000_0000);

    for (int i = 0; i < 30; i++) begin
      o = ops[$urandom_range(0, 5)];
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      v = ($urandom_range(0, 7) != 0);
      if (o == OpDiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      issue(o, a, b, v);
      chk("rnd_zero", {63'b0, div_zero}, {63'b0, (v && o == OpDiv && b == 0)});
      wait_idle(cyc);
      chk("rnd_hilo", {hi, lo}, {hi_m, lo_m});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 SHALL have parameter DIV_TIMEOUT, default 40, max cycles to wait for the divider before abort.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port op_valid  input  1  an instruction is issued this cycle.
REQ-005 SHALL have port op  input  3  operation code from md_pkg: NOP, DIV, MULT, MULTU, MTHI, MTLO.
REQ-006 SHALL have ports rs_val, rt_val  input  32  each; operand A (dividend/multiplicand/move source) and operand B.
REQ-007 SHALL have port hi, lo  output  32  each; architectural HI/LO registers.
REQ-008 SHALL have port stall  output  1  pipeline must hold issue and MFHI/MFLO.
REQ-009 SHALL have ports div_start  output  1, div_dividend, div_divisor  output  32; drive the signed iterative divider.
REQ-010 SHALL have ports div_q, div_r  input  32, div_busy  input  1; divider results and status.
REQ-011 SHALL have ports div_zero, div_err  output  1  each; one-cycle pulses: divide-by-zero, divider timeout.

Function
REQ-012 SHALL implement FSM states IDLE, DIV_ARM, DIV_RUN, DIV_DONE; stall = (state != IDLE).
REQ-013 SHALL accept op only when op_valid=1 and state=IDLE; ops presented while stall=1 are ignored.
REQ-014 MULT SHALL write {hi,lo} = signed 64-bit product of rs_val*rt_val at the next rising edge; no stall.
REQ-015 MULTU SHALL write {hi,lo} = unsigned 64-bit product at the next rising edge; no stall.
REQ-016 MTHI/MTLO SHALL write rs_val to hi/lo at the next rising edge, other register unchanged.
REQ-017 DIV with rt_val != 0 SHALL register operands onto div_dividend/div_divisor, assert div_start, enter DIV_ARM.
REQ-018 div_start SHALL remain 1 for the whole DIV_ARM state and 0 in every other state.
REQ-019 DIV_ARM -> DIV_RUN when div_busy=1 sampled; DIV_RUN -> DIV_DONE when div_busy=0 sampled.
REQ-020 DIV_DONE SHALL write lo=div_q, hi=div_r and return to IDLE; stall falls the cycle after DIV_DONE.
REQ-021 div_dividend/div_divisor SHALL stay stable from DIV_ARM entry until IDLE.
REQ-022 DIV with rt_val == 0 SHALL leave hi/lo unchanged, pulse div_zero one cycle, stay IDLE, never assert div_start.
REQ-023 A 6-bit cycle counter SHALL clear on DIV_ARM entry; reaching DIV_TIMEOUT in DIV_ARM or DIV_RUN SHALL pulse div_err, leave hi/lo unchanged, return to IDLE.
REQ-024 Nominal DIV latency (issue edge to stall low) SHALL be 32-36 cycles with the 32-iteration divider.
REQ-025 NOP or op_valid=0 SHALL change no state.

Reset
REQ-026 reset=0 SHALL asynchronously force state=IDLE, hi=0, lo=0, div_start=0, div_zero=0, div_err=0, counter=0, operand registers=0.
REQ-027 reset asserted mid-divide SHALL abort the divide; no hi/lo write after release; first edge after release accepts new ops.

Structure
REQ-028 md_pkg SHALL hold op encodings, FSM state enum and DIV_TIMEOUT default.
REQ-029 The 32x32 signed/unsigned product SHALL live in one combinational sub-module mult32 (inputs a, b, is_signed; output 64-bit p).
REQ-030 The divider SHALL be instantiated outside hilo_ctrl and connected only through the div_* ports.

Verification
REQ-031 MULT rs=0xFFFFFFFF rt=0x2 -> next edge hi=0xFFFFFFFF lo=0xFFFFFFFE; MULTU same operands -> hi=0x00000001 lo=0xFFFFFFFE.
REQ-032 DIV rs=7 rt=2 -> stall 32-36 cycles, then lo=0x00000003 hi=0x00000001; DIV rs=-7 rt=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
REQ-033 DIV rs=5 rt=0 with hi=0x11, lo=0x22 -> div_zero pulse 1 cycle, stall never 1, hi/lo unchanged.
REQ-034 MTHI 0xA during divide (stall=1) -> ignored; hi after divide equals divider remainder.
REQ-035 reset low 10 cycles into DIV 100/3 -> hi=lo=0, stall=0, div_start=0 immediately; no later write.
REQ-036 divider model holding div_busy=0 forever -> div_err pulse after DIV_TIMEOUT cycles, state IDLE, hi/lo unchanged.
